pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Parametrised program-counter generator for the fetch stage; supersedes the bare 8-bit PC register.
//  Holds the current instruction address and sequences it: reset vector, sequential step, branch/jump/trap redirect.
//  Supports stall, halt/resume and a fetch valid/ready handshake. Feeds instruction-memory address and the PC+STEP adder path.
// PARAMETERS
//  XLEN       8      PC width in bits
//  STEP       1      sequential increment (address units per instruction); must be < 2**XLEN
//  RESET_VEC  0      PC value loaded on reset
//  TRAP_VEC   'hF0   PC value loaded on trap; XLEN-bit
// PORTS
//  clk            in   1     system clock, rising edge
//  reset          in   1     asynchronous, active-low reset
//  stall          in   1     hold PC; blocks sequential advance only
//  branch_taken   in   1     conditional branch resolved taken this cycle
//  branch_target  in   XLEN  branch destination
//  jump           in   1     unconditional jump this cycle
//  jump_target    in   XLEN  jump destination
//  trap           in   1     exception/trap request
//  halt_req       in   1     request to halt fetch
//  resume         in   1     leave HALT
//  fetch_ready    in   1     fetch/IMEM accepts pc this cycle
//  pc             out  XLEN  current PC (registered)
//  pc_plus        out  XLEN  pc + STEP, modulo 2**XLEN (combinational from pc)
//  pc_valid       out  1     pc is a valid fetch address
//  halted         out  1     state == HALT
//  wrapped        out  1     sticky: a sequential advance overflowed past 2**XLEN-1
// BEHAVIOUR
//  Reset (reset==0, async): pc=RESET_VEC, state=BOOT, pc_valid=0, halted=0, wrapped=0.
//  States: BOOT, RUN, HALT; all updates on rising clk.
//   BOOT: pc_valid=0; next cycle -> RUN unconditionally, pc unchanged (RESET_VEC). Redirect inputs ignored.
//   RUN : pc_valid=1. Next-PC priority, highest first:
//         trap -> TRAP_VEC; jump -> jump_target; branch_taken -> branch_target;
//         (fetch_ready && !stall) -> pc+STEP; else hold.
//         Redirects (trap/jump/branch) apply regardless of stall and fetch_ready (flush semantics).
//         halt_req with no redirect: pc held, -> HALT. halt_req with redirect: redirect applied AND -> HALT.
//         trap overrides halt_req: trap taken, stay RUN.
//   HALT: pc_valid=0, halted=1, pc held; jump/branch/stall ignored.
//         resume -> RUN next cycle, pc unchanged. trap -> pc=TRAP_VEC and -> RUN (trap beats resume).
//  Handshake: a fetch of pc completes when pc_valid && fetch_ready; pc advances sequentially only on that cycle and only if !stall.
//  pc_valid never deasserts in RUN except on the transition edge into HALT.
//  Arithmetic: pc+STEP computed in XLEN+1 bits; carry-out on a sequential advance sets wrapped (sticky until reset); pc takes low XLEN bits.
//   Redirect targets never set wrapped.
//  Latency: redirect inputs sampled at edge N appear on pc after edge N (1 cycle); pc_plus follows pc same cycle.
//  Reset mid-operation: immediate return to reset state, any pending redirect/halt discarded.
// TESTING
//  T1 reset low then release, fetch_ready=1 -> pc=0x00 valid=0 for 1 cycle (BOOT), then 0x00,0x01,0x02 with pc_valid=1.
//  T2 RUN at pc=0x05, stall=1 two cycles, then branch_taken=1 target=0x40 with stall=1 -> pc holds 0x05, then 0x40.
//  T3 same cycle trap=1, jump=1 (0x20), branch_taken=1 (0x30) -> pc=0xF0; next cycle jump only -> pc=0x20.
//  T4 pc=0xFF, fetch_ready=1 -> pc=0x00, wrapped=1 and stays 1 through later jumps until reset.
//  T5 halt_req at pc=0x10 -> halted=1, pc_valid=0, pc=0x10 held 3 cycles with jump ignored; resume -> RUN, pc_valid=1, pc=0x10, then 0x11.
//  T6 fetch_ready=0 in RUN for 4 cycles -> pc holds; assert reset mid-HALT -> pc=RESET_VEC, halted=0, wrapped=0 asynchronously.

Source files
------------

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-side bundle for the program-counter generator.
//   Control/redirect inputs (driven by the core/fetch logic):
//     stall, branch_taken, branch_target, jump, jump_target, trap,
//     halt_req, resume, fetch_ready
//   Status outputs (driven by pc_gen):
//     pc, pc_plus, pc_valid, halted, wrapped
// modport slave is the pc_gen side; modport master is the side that drives control.
interface pc_gen_if #(
  parameter int XLEN = 8
);
  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            jump;
  logic [XLEN-1:0] jump_target;
  logic            trap;
  logic            halt_req;
  logic            resume;
  logic            fetch_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus;
  logic            pc_valid;
  logic            halted;
  logic            wrapped;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target,
           trap, halt_req, resume, fetch_ready,
    input  pc, pc_plus, pc_valid, halted, wrapped
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target,
           trap, halt_req, resume, fetch_ready,
    output pc, pc_plus, pc_valid, halted, wrapped
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the fetch stage.
//   Ports:
//     clk    - system clock, rising edge
//     reset  - asynchronous, active-low reset
//     bus    - pc_gen_if.slave: redirect/stall/halt/handshake inputs,
//              pc, pc_plus, pc_valid, halted, wrapped outputs
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   BOOT  | one cycle after reset, pc = RESET_VEC not yet valid
//   RUN   | pc valid; sequential advance on accepted fetch, redirects
//   HALT  | fetch stopped, pc held; leaves on resume or trap
module pc_gen #(
  parameter int              XLEN      = 8,
  parameter int              STEP      = 1,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(0),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('hF0)
) (
  input logic      clk,
  input logic      reset,
  pc_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [XLEN:0] STEP_EXT = (XLEN+1)'(STEP);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            wrapped_q, wrapped_d;
  logic [XLEN:0]   sum;

  // One extra bit so the carry-out of a sequential step is visible.
  assign sum = {1'b0, pc_q} + STEP_EXT;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_VEC;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      wrapped_q <= wrapped_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wrapped_d = wrapped_q;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        // Redirects flush regardless of stall/fetch_ready; a halt request
        // without a redirect suppresses the sequential step.
        if (bus.trap) begin
          pc_d = TRAP_VEC;
        end else if (bus.jump) begin
          pc_d = bus.jump_target;
        end else if (bus.branch_taken) begin
          pc_d = bus.branch_target;
        end else if (!bus.halt_req && bus.fetch_ready && !bus.stall) begin
          pc_d = sum[XLEN-1:0];
          if (sum[XLEN]) wrapped_d = 1'b1;
        end
        if (bus.halt_req && !bus.trap) state_d = S_HALT;
      end
      S_HALT: begin
        if (bus.trap) begin
          pc_d    = TRAP_VEC;
          state_d = S_RUN;
        end else if (bus.resume) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_BOOT;
        pc_d    = RESET_VEC;
      end
    endcase
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus  = sum[XLEN-1:0];
  assign bus.pc_valid = (state_q == S_RUN);
  assign bus.halted   = (state_q == S_HALT);
  assign bus.wrapped  = wrapped_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;
  localparam int XLEN = 8;
  localparam int TRAP = 'hF0;

  logic clk;
  logic reset;
  int   checks;
  int   fails;

  // Reference model: pc as an integer address, mode 0=boot 1=run 2=halt.
  int m_pc;
  int m_mode;
  bit m_wrap;

  pc_gen_if #(.XLEN(XLEN)) bus ();

  pc_gen #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [18:0] exp_vec();
    return {8'(m_pc), 8'((m_pc + 1) % 256), (m_mode == 1), (m_mode == 2), m_wrap};
  endfunction

  function automatic logic [18:0] act_vec();
    return {bus.pc, bus.pc_plus, bus.pc_valid, bus.halted, bus.wrapped};
  endfunction

  task automatic clear_inputs();
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = '0;
    bus.jump = 0; bus.jump_target = '0; bus.trap = 0;
    bus.halt_req = 0; bus.resume = 0; bus.fetch_ready = 0;
  endtask

  // Advance model and DUT by one rising edge using the currently driven inputs.
  task automatic advance();
    int np = m_pc;
    int nm = m_mode;
    if (m_mode == 0) begin
      nm = 1;
    end else if (m_mode == 1) begin
      if (bus.trap) np = TRAP;
      else if (bus.jump) np = int'(bus.jump_target);
      else if (bus.branch_taken) np = int'(bus.branch_target);
      else if (!bus.halt_req && bus.fetch_ready && !bus.stall) begin
        np = m_pc + 1;
        if (np > 255) begin np = np - 256; m_wrap = 1; end
      end
      if (bus.halt_req && !bus.trap) nm = 2;
    end else begin
      if (bus.trap) begin np = TRAP; nm = 1; end
      else if (bus.resume) nm = 1;
    end
    @(posedge clk);
    m_pc = np;
    m_mode = nm;
    #1;
  endtask

  task automatic jump_to(input int tgt);
    clear_inputs();
    bus.jump = 1; bus.jump_target = 8'(tgt);
    advance();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.fetch_ready = 1;
    reset = 0;
    m_pc = 0; m_mode = 0; m_wrap = 0;
    #2;
    checks++;
    if (act_vec() !== exp_vec()) begin
      fails++; $display("FAIL reset_async: got %h expected %h", act_vec(), exp_vec());
    end
    @(negedge clk);
    reset = 1;
    #1;
    checks++;
    if (bus.pc !== 8'h00 || bus.pc_valid !== 1'b0) begin
      fails++; $display("FAIL boot_state: got pc=%h valid=%b expected pc=00 valid=0", bus.pc, bus.pc_valid);
    end
    for (int i = 0; i < 3; i++) begin
      advance();
      checks++;
      if (act_vec() !== exp_vec() || bus.pc !== 8'(i)) begin
        fails++; $display("FAIL boot_seq[%0d]: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_stall_branch();
    jump_to('h05);
    bus.fetch_ready = 1; bus.stall = 1;
    for (int i = 0; i < 2; i++) begin
      advance();
      checks++;
      if (act_vec() !== exp_vec() || bus.pc !== 8'h05) begin
        fails++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
    bus.branch_taken = 1; bus.branch_target = 8'h40;
    advance();
    checks++;
    if (act_vec() !== exp_vec() || bus.pc !== 8'h40) begin
      fails++; $display("FAIL branch_under_stall: got %h expected %h", act_vec(), exp_vec());
    end
    clear_inputs();
  endtask

  task automatic test_priority();
    clear_inputs();
    bus.trap = 1; bus.jump = 1; bus.jump_target = 8'h20;
    bus.branch_taken = 1; bus.branch_target = 8'h30; bus.halt_req = 1;
    advance();
    checks++;
    if (act_vec() !== exp_vec() || bus.pc !== 8'hF0 || bus.pc_valid !== 1'b1) begin
      fails++; $display("FAIL trap_priority: got %h expected %h", act_vec(), exp_vec());
    end
    clear_inputs();
    bus.jump = 1; bus.jump_target = 8'h20;
    advance();
    checks++;
    if (act_vec() !== exp_vec() || bus.pc !== 8'h20) begin
      fails++; $display("FAIL jump_only: got %h expected %h", act_vec(), exp_vec());
    end
    clear_inputs();
  endtask

  task automatic test_wrap();
    jump_to('hFF);
    checks++;
    if (act_vec() !== exp_vec() || bus.pc_plus !== 8'h00 || bus.wrapped !== 1'b0) begin
      fails++; $display("FAIL pre_wrap: got %h expected %h", act_vec(), exp_vec());
    end
    bus.fetch_ready = 1;
    advance();
    checks++;
    if (act_vec() !== exp_vec() || bus.pc !== 8'h00 || bus.wrapped !== 1'b1) begin
      fails++; $display("FAIL wrap_step: got %h expected %h", act_vec(), exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      jump_to($urandom_range(0, 255));
      checks++;
      if (act_vec() !== exp_vec() || bus.wrapped !== 1'b1) begin
        fails++; $display("FAIL wrap_sticky[%0d]: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_halt();
    jump_to('h10);
    bus.fetch_ready = 1; bus.halt_req = 1;
    advance();
    checks++;
    if (act_vec() !== exp_vec() || bus.halted !== 1'b1 || bus.pc !== 8'h10) begin
      fails++; $display("FAIL halt_enter: got %h expected %h", act_vec(), exp_vec());
    end
    bus.halt_req = 0;
    for (int i = 0; i < 3; i++) begin
      bus.jump = 1; bus.jump_target = 8'($urandom_range(0, 255));
      bus.branch_taken = 1; bus.branch_target = 8'($urandom_range(0, 255));
      advance();
      checks++;
      if (act_vec() !== exp_vec() || bus.pc !== 8'h10 || bus.pc_valid !== 1'b0) begin
        fails++; $display("FAIL halt_hold[%0d]: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
    clear_inputs();
    bus.fetch_ready = 1; bus.resume = 1;
    advance();
    bus.resume = 0;
    checks++;
    if (act_vec() !== exp_vec() || bus.pc !== 8'h10 || bus.pc_valid !== 1'b1) begin
      fails++; $display("FAIL resume: got %h expected %h", act_vec(), exp_vec());
    end
    advance();
    checks++;
    if (act_vec() !== exp_vec() || bus.pc !== 8'h11) begin
      fails++; $display("FAIL resume_step: got %h expected %h", act_vec(), exp_vec());
    end
    // Halt combined with a redirect, then trap beating resume in HALT.
    bus.halt_req = 1; bus.jump = 1; bus.jump_target = 8'h66;
    advance();
    clear_inputs();
    checks++;
    if (act_vec() !== exp_vec() || bus.pc !== 8'h66 || bus.halted !== 1'b1) begin
      fails++; $display("FAIL halt_with_jump: got %h expected %h", act_vec(), exp_vec());
    end
    bus.trap = 1; bus.resume = 1;
    advance();
    clear_inputs();
    checks++;
    if (act_vec() !== exp_vec() || bus.pc !== 8'hF0 || bus.pc_valid !== 1'b1) begin
      fails++; $display("FAIL halt_trap: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_fetch_ready_reset();
    jump_to('h33);
    for (int i = 0; i < 4; i++) begin
      advance();
      checks++;
      if (act_vec() !== exp_vec() || bus.pc !== 8'h33) begin
        fails++; $display("FAIL no_ready_hold[%0d]: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
    bus.halt_req = 1;
    advance();
    clear_inputs();
    #2;
    reset = 0;
    m_pc = 0; m_mode = 0; m_wrap = 0;
    #1;
    checks++;
    if (act_vec() !== exp_vec() || bus.halted !== 1'b0 || bus.wrapped !== 1'b0) begin
      fails++; $display("FAIL reset_mid_halt: got %h expected %h", act_vec(), exp_vec());
    end
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.stall         = ($urandom_range(0, 3) == 0);
      bus.fetch_ready   = ($urandom_range(0, 3) != 0);
      bus.trap          = ($urandom_range(0, 15) == 0);
      bus.jump          = ($urandom_range(0, 11) == 0);
      bus.jump_target   = 8'($urandom_range(0, 255));
      bus.branch_taken  = ($urandom_range(0, 7) == 0);
      bus.branch_target = 8'($urandom_range(0, 255));
      bus.halt_req      = ($urandom_range(0, 15) == 0);
      bus.resume        = ($urandom_range(0, 3) == 0);
      advance();
      checks++;
      if (act_vec() !== exp_vec()) begin
        fails++; $display("FAIL random[%0d]: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 0;
    clear_inputs();
    test_reset();
    test_stall_branch();
    test_priority();
    test_wrap();
    test_halt();
    test_fetch_ready_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
